// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control FSM.
// MULTICYCLE_CTRL_ITYPE_EN adds the I-type ALU path (EXECI state).
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_BEQ      = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Successor of DECODE; unsupported opcodes fall back to FETCH.
  function automatic state_e decode_next(input logic [6:0] op);
    state_e nxt;
    nxt = S_FETCH;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_RTYPE:          nxt = S_EXECR;
      OP_BRANCH:         nxt = S_BEQ;
`ifdef MULTICYCLE_CTRL_ITYPE_EN
      OP_ITYPE:          nxt = S_EXECI;
`endif
      default:           nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    return decode_next(op) != S_FETCH;
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> datapath controls; zero latency, outputs forced low in reset.
// pc_write is the only output that also depends on the live ALU zero flag.
module ctrl_out_decode
  import multicycle_pkg::*;
(
  input  logic       rst_n,
  input  logic [3:0] state_in,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  logic pc_update;
  logic branch;

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    reg_write  = 1'b0;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_in)
        S_FETCH: begin
          ir_write   = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALUOP_ADD;
          result_src = RES_ALU;
          pc_update  = 1'b1;
        end
        S_DECODE: begin
          // Precompute branch target into ALUOut while decoding.
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          illegal   = ~op_legal(opcode);
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEMREAD: begin
          adr_src    = 1'b1;
          result_src = RES_ALUOUT;
        end
        S_MEMWB: begin
          result_src = RES_MEMDATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src    = 1'b1;
          result_src = RES_ALUOUT;
          mem_write  = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_ITYPE_EN
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
        end
`endif
        S_BEQ: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALUOP_SUB;
          result_src = RES_ALUOUT;
          branch     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_write = pc_update | (branch & zero);
  assign state    = rst_n ? state_in : 4'd0;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 main control FSM: 3-5 cycles per instruction, no backpressure.
// Define MULTICYCLE_CTRL_ITYPE_EN to add the I-type ALU path (opcode 0010011).
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;

  // Opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = decode_next(opcode);
      S_MEMADR:  state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR:   state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ITYPE_EN
      S_EXECI:   state_d = S_ALUWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  ctrl_out_decode u_out (
    .rst_n      (rst_n),
    .state_in   (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl; expected per-cycle outputs come from
// an instruction-level model (opcode -> state walk, state -> control table).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;

`ifdef MULTICYCLE_CTRL_ITYPE_EN
  localparam bit ITYPE_ON = 1'b1;
`else
  localparam bit ITYPE_ON = 1'b0;
`endif

  logic [17:0] exp_q[$];
  int          st_q[$];
  int          instr_q[$];
  int          seq[$];
  int          checks = 0;
  int          passed = 0;
  int          instr_no = 0;
  bit          done = 1'b0;

  function automatic bit legal(input logic [6:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (ITYPE_ON && op == IT);
  endfunction

  // State walk of one instruction, straight from the cycle-count table.
  function automatic void walk(input logic [6:0] op);
    if (op == LW)                   seq = '{0, 1, 2, 3, 4};
    else if (op == SW)              seq = '{0, 1, 2, 5};
    else if (op == RT)              seq = '{0, 1, 6, 7};
    else if (op == BEQ)             seq = '{0, 1, 9};
    else if (ITYPE_ON && op == IT)  seq = '{0, 1, 8, 7};
    else                            seq = '{0, 1};
  endfunction

  // Packed as {pc_write, adr_src, mem_write, ir_write, result_src, a, b, reg_write, alu_op, illegal, state}.
  function automatic logic [17:0] model(input int s, input logic z, input logic [6:0] op);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, a, b, aop;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {res, a, b, aop} = '0;
    case (s)
      0: begin irw = 1; b = 2'd2; res = 2'd2; pcw = 1; end
      1: begin a = 2'd1; b = 2'd1; ill = !legal(op); end
      2: begin a = 2'd2; b = 2'd1; end
      3: begin adr = 1; end
      4: begin res = 2'd1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin a = 2'd2; aop = 2'd2; end
      7: begin rw = 1; end
      8: begin a = 2'd2; b = 2'd1; aop = 2'd2; end
      9: begin a = 2'd2; aop = 2'd1; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, res, a, b, rw, aop, ill, 4'(s)};
  endfunction

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n  = 1'b0;
      opcode = 7'($urandom);
      zero   = 1'($urandom);
      exp_q.push_back(18'd0);
      st_q.push_back(0);
      instr_q.push_back(-1);
    end
  endtask

  // zmode: 0/1 force zero, 2 random. ncyc < 0 runs the whole instruction.
  task automatic run_instr(input logic [6:0] op, input int zmode, input int ncyc);
    int n;
    walk(op);
    n = (ncyc < 0 || ncyc > seq.size()) ? seq.size() : ncyc;
    instr_no++;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n  = 1'b1;
      opcode = (seq[i] == 1 || seq[i] == 2) ? op : 7'($urandom);
      zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      exp_q.push_back(model(seq[i], zero, op));
      st_q.push_back(seq[i]);
      instr_q.push_back(instr_no);
    end
  endtask

  initial begin : monitor
    logic [17:0] e, act;
    int s, k;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        s   = st_q.pop_front();
        k   = instr_q.pop_front();
        act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               reg_write, alu_op, illegal, state};
        checks++;
        if (act !== e)
          $display("FAIL outputs instr=%0d exp_state=%0d t=%0t actual=%b required=%b", k, s, $time, act, e);
        else
          passed++;
      end
    end
  end

  initial begin : stimulus
    logic [6:0] op;
    int pick;
    rst_n  = 1'b0;
    opcode = '0;
    zero   = 1'b0;
    reset_cycles(3);
    run_instr(LW, 2, -1);
    run_instr(SW, 2, -1);
    run_instr(BEQ, 1, -1);
    run_instr(BEQ, 0, -1);
    run_instr(RT, 2, -1);
    run_instr(7'h7f, 2, -1);
    run_instr(IT, 2, -1);
    // Reset lands while the store sits in MEMWRITE, held for 3 cycles.
    run_instr(SW, 2, 3);
    reset_cycles(3);
    run_instr(LW, 2, -1);
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = IT;
        4: op = BEQ;
        default: begin
          op = 7'($urandom);
          while (legal(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, 2, -1);
      if ($urandom_range(0, 40) == 0) reset_cycles($urandom_range(1, 3));
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    else
      passed++;
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    if (!done) begin
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multi-cycle RV32 core: sequences every instruction through fetch, decode, execute, memory and writeback cycles and drives all datapath enables and mux selects. Sits directly upstream of the ALU-control decoder, supplying its 2-bit `ALUOp` (00 add, 01 sub, 10 decode by funct3/funct7). One instruction completes every 3–5 cycles.

## Interface
- No parameters.
- `clk` in 1 — single clock, all state updates on rising edge.
- `rst_n` in 1 — synchronous reset, active-low.
- `opcode` in 7 — `instr[6:0]` from the instruction register, valid from DECODE onward.
- `zero` in 1 — ALU zero flag.
- `pc_write` out 1 — PC register enable.
- `adr_src` out 1 — memory address select: 0 = PC, 1 = ALU result register.
- `mem_write` out 1 — data memory write enable.
- `ir_write` out 1 — instruction and old-PC register enable.
- `result_src` out 2 — result select: 00 ALUOut register, 01 memory data register, 10 ALU result.
- `alu_src_a` out 2 — A select: 00 PC, 01 old PC, 10 rs1 register.
- `alu_src_b` out 2 — B select: 00 rs2 register, 01 immediate, 10 constant 4.
- `reg_write` out 1 — register-file write enable.
- `alu_op` out 2 — to ALU control.
- `illegal` out 1 — unsupported-opcode pulse.
- `state` out 4 — current state, for debug.

## Operation
- Moore outputs decoded from `state`, except `pc_write = pc_update | (branch & zero)`. Neither `pc_update` nor `branch` is a port.
- Every output not listed for a state below is 0.
- States, encodings and transitions:
  - FETCH (0): `adr_src`=0, `ir_write`=1, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10, `pc_update`=1. Next: DECODE.
  - DECODE (1): `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch target into ALUOut). Next:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 1100011 → BEQ
    - 0010011 → EXECI (macro only)
    - otherwise `illegal`=1 for this cycle, then FETCH
  - MEMADR (2): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next: MEMREAD if `opcode[5]`=0, else MEMWRITE.
  - MEMREAD (3): `adr_src`=1, `result_src`=00. Next: MEMWB.
  - MEMWB (4): `result_src`=01, `reg_write`=1. Next: FETCH.
  - MEMWRITE (5): `adr_src`=1, `result_src`=00, `mem_write`=1. Next: FETCH.
  - EXECR (6): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next: ALUWB.
  - ALUWB (7): `result_src`=00, `reg_write`=1. Next: FETCH.
  - EXECI (8): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next: ALUWB.
  - BEQ (9): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1. Next: FETCH.
- Encodings 10–15 are unreachable. If ever entered: all outputs 0, next state FETCH.
- `opcode` is sampled only in DECODE and MEMADR; changes in other states are ignored.

## Timing
- Reset:
  - `rst_n`=0 at a rising edge loads FETCH.
  - While `rst_n`=0, all outputs are forced to 0 combinationally; `state` reads 0. This holds even mid-instruction, so no write fires during reset.
  - First fetch happens in the first cycle with `rst_n`=1.
- Cycles per instruction: lw 5; sw 4; R-type 4; I-type 4; beq 3; illegal 2.
- `pc_write` in BEQ follows `zero` in the same cycle, with no registering.
- `illegal` is high for exactly one cycle (DECODE).

## Configuration
- `MULTICYCLE_CTRL_ITYPE_EN` defined:
  - EXECI exists; opcode 0010011 → EXECI → ALUWB.
  - `alu_op`=10 in EXECI; the datapath clears `func7_5` for I-type before ALU control.
- Macro undefined:
  - Opcode 0010011 is illegal: `illegal` pulse, return to FETCH.
  - Encoding 8 is unreachable.

## Structure
- Shared package `multicycle_pkg`:
  - state enum (4-bit);
  - opcode constants `OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_BRANCH`;
  - `ALUOP_ADD`/`ALUOP_SUB`/`ALUOP_FUNCT`;
  - `result_src`, `alu_src_a` and `alu_src_b` encodings.
- One sub-module, `ctrl_out_decode`: combinational state → outputs, including reset gating and the `pc_write` equation.
- State register and next-state logic live in `multicycle_ctrl`.

## Test plan
- Reset held 3 cycles mid-MEMWRITE → all outputs 0 during reset; `state`=0; first released cycle shows `ir_write`=1, `pc_write`=1.
- lw (opcode 0000011) → states 0,1,2,3,4,0; `reg_write`=1 only in state 4 with `result_src`=01.
- sw (0100011) → 0,1,2,5,0; `mem_write`=1 only in state 5 with `adr_src`=1.
- beq with `zero`=1, then with `zero`=0 → 0,1,9; `pc_write`=1 in state 9 only when `zero`=1; `alu_op`=01 in state 9.
- R-type (0110011) → 0,1,6,7,0 with `alu_op`=10 in state 6. Opcode 1111111 → `illegal` pulse in DECODE, then FETCH.
- 0010011 with macro defined → 0,1,8,7,0 with `alu_src_b`=01; without macro → `illegal`=1, back to FETCH.
